// File: rtl/binary_search_8bit.sv
// Binary search over [0, 2^WIDTH-1] driven by less/equal/great verdicts on each guess.
// Optional timeout aborts a search whose feedback never arrives.
module binary_search_8bit #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    input  logic             fb_valid,
    input  logic             fb_less,
    input  logic             fb_equal,
    input  logic             fb_great,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       steps
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ASK,
        S_FINISH
    } state_t;

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLIMIT = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       steps_q, steps_d;
    logic             found_q, found_d;
    logic             error_q, error_d;
    logic [TW-1:0]    timer_q, timer_d;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        steps_d  = steps_q;
        found_d  = found_q;
        error_d  = error_q;
        timer_d  = timer_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = '1;
                    steps_d  = '0;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                // Sum carried in WIDTH+1 bits so lo+hi cannot wrap.
                guess_d = WIDTH'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
                timer_d = '0;
                state_d = S_ASK;
            end
            S_ASK: begin
                if (fb_valid) begin
                    steps_d = steps_q + 4'd1;
                    case ({fb_less, fb_equal, fb_great})
                        3'b010: begin
                            result_d = guess_q;
                            found_d  = 1'b1;
                            state_d  = S_FINISH;
                        end
                        3'b100: begin
                            if (guess_q == '1) begin
                                error_d = 1'b1;
                                state_d = S_FINISH;
                            end else begin
                                lo_d = guess_q + 1'b1;
                                if (lo_d > hi_q) begin
                                    error_d = 1'b1;
                                    state_d = S_FINISH;
                                end else begin
                                    state_d = S_CALC;
                                end
                            end
                        end
                        3'b001: begin
                            if (guess_q == '0) begin
                                error_d = 1'b1;
                                state_d = S_FINISH;
                            end else begin
                                hi_d = guess_q - 1'b1;
                                if (lo_q > hi_d) begin
                                    error_d = 1'b1;
                                    state_d = S_FINISH;
                                end else begin
                                    state_d = S_CALC;
                                end
                            end
                        end
                        default: begin
                            error_d = 1'b1;
                            state_d = S_FINISH;
                        end
                    endcase
                end else if (TIMEOUT > 0 && timer_q == TLIMIT) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            found_q  <= found_d;
            error_q  <= error_d;
            timer_q  <= timer_d;
        end
    end

    assign guess       = guess_q;
    assign guess_valid = (state_q == S_ASK);
    assign busy        = (state_q == S_CALC) || (state_q == S_ASK);
    assign done        = (state_q == S_FINISH);
    assign found       = found_q;
    assign error       = error_q;
    assign result      = result_q;
    assign steps       = steps_q;

endmodule

// File: tb/tb_binary_search_8bit.sv
// Directed bench for binary_search_8bit: vector table of responder modes plus
// hand-written stray-input, reset and timeout sequences.
module tb_binary_search_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] guess;
    logic       guess_valid;
    logic       fb_valid, fb_less, fb_equal, fb_great;
    logic       busy, done, found, error;
    logic [7:0] result;
    logic [3:0] steps;

    logic       start2;
    logic [7:0] guess2;
    logic       guess_valid2;
    logic       fb_valid2, fb_less2, fb_equal2, fb_great2;
    logic       busy2, done2, found2, error2;
    logic [7:0] result2;
    logic [3:0] steps2;

    always #5 clk = ~clk;

    binary_search_8bit #(.WIDTH(8), .TIMEOUT(0)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .guess(guess), .guess_valid(guess_valid),
        .fb_valid(fb_valid), .fb_less(fb_less), .fb_equal(fb_equal), .fb_great(fb_great),
        .busy(busy), .done(done), .found(found), .error(error),
        .result(result), .steps(steps)
    );

    binary_search_8bit #(.WIDTH(8), .TIMEOUT(5)) u_tmo (
        .clk(clk), .rst(rst), .start(start2),
        .guess(guess2), .guess_valid(guess_valid2),
        .fb_valid(fb_valid2), .fb_less(fb_less2), .fb_equal(fb_equal2), .fb_great(fb_great2),
        .busy(busy2), .done(done2), .found(found2), .error(error2),
        .result(result2), .steps(steps2)
    );

    localparam int M_CMP   = 0;
    localparam int M_LESS  = 1;
    localparam int M_GREAT = 2;
    localparam int M_BOTH  = 3;
    localparam int M_NONE  = 4;

    typedef struct {
        int         mode;
        logic [7:0] tgt;
        int         ng;
        logic       exp_found;
        logic       exp_error;
        logic [7:0] exp_result;
        int         g[9];
    } vec_t;

    vec_t vecs[9];

    int         total = 0;
    int         bad   = 0;
    int         gq[$];
    int         done_n;
    logic       got_done;
    logic       s_found, s_error;
    logic [7:0] s_result;
    logic [3:0] s_steps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive_fb(input int mode, input logic [7:0] tgt, input logic [7:0] g);
        fb_valid = 1'b1;
        case (mode)
            M_CMP:   begin fb_less = (g < tgt); fb_equal = (g == tgt); fb_great = (g > tgt); end
            M_LESS:  fb_less = 1'b1;
            M_GREAT: fb_great = 1'b1;
            M_BOTH:  begin fb_less = 1'b1; fb_great = 1'b1; end
            default: ;
        endcase
    endtask

    // Runs one search from a negedge; with chaos, pokes start mid-search and in
    // FINISH, and a bogus fb_valid+fb_equal while the DUT is computing.
    task automatic run(input int mode, input logic [7:0] tgt, input bit chaos);
        gq.delete();
        got_done = 1'b0;
        done_n   = 0;
        start    = 1'b1;
        for (int n = 1; n <= 60 && !got_done; n++) begin
            @(negedge clk);
            start = 1'b0;
            fb_valid = 1'b0; fb_less = 1'b0; fb_equal = 1'b0; fb_great = 1'b0;
            if (done) begin
                got_done = 1'b1;
                done_n   = n;
                s_found  = found;
                s_error  = error;
                s_result = result;
                s_steps  = steps;
                check("gv_low_at_done", guess_valid, 0);
                check("busy_low_at_done", busy, 0);
                if (chaos) start = 1'b1;
            end else if (guess_valid) begin
                gq.push_back(int'(guess));
                drive_fb(mode, tgt, guess);
                if (chaos && gq.size() == 2) start = 1'b1;
            end else if (chaos && busy) begin
                fb_valid = 1'b1;
                fb_equal = 1'b1;
            end
        end
        if (!got_done) check("done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        fb_valid = 1'b0; fb_less = 1'b0; fb_equal = 1'b0; fb_great = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_after_finish", busy, 0);
        check("found_held", found, s_found);
        check("result_held", result, s_result);
    endtask

    task automatic check_vec(input int k, input int exp_done_n);
        check($sformatf("v%0d_nguess", k), gq.size(), vecs[k].ng);
        for (int i = 0; i < vecs[k].ng; i++)
            check($sformatf("v%0d_guess%0d", k, i), (i < gq.size()) ? gq[i] : -1, vecs[k].g[i]);
        check($sformatf("v%0d_steps", k), s_steps, vecs[k].ng);
        check($sformatf("v%0d_found", k), s_found, vecs[k].exp_found);
        check($sformatf("v%0d_error", k), s_error, vecs[k].exp_error);
        check($sformatf("v%0d_result", k), s_result, vecs[k].exp_result);
        check($sformatf("v%0d_done_cycle", k), done_n, exp_done_n);
    endtask

    initial begin
        int m;
        logic seen;

        vecs[0] = '{M_CMP,   8'd255, 9, 1'b1, 1'b0, 8'd255, '{127, 191, 223, 239, 247, 251, 253, 254, 255}};
        vecs[1] = '{M_CMP,   8'd0,   8, 1'b1, 1'b0, 8'd0,   '{127, 63, 31, 15, 7, 3, 1, 0, 0}};
        vecs[2] = '{M_CMP,   8'd127, 1, 1'b1, 1'b0, 8'd127, '{127, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{M_LESS,  8'd0,   9, 1'b0, 1'b1, 8'd0,   '{127, 191, 223, 239, 247, 251, 253, 254, 255}};
        vecs[4] = '{M_GREAT, 8'd0,   8, 1'b0, 1'b1, 8'd0,   '{127, 63, 31, 15, 7, 3, 1, 0, 0}};
        vecs[5] = '{M_BOTH,  8'd0,   1, 1'b0, 1'b1, 8'd0,   '{127, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[6] = '{M_NONE,  8'd0,   1, 1'b0, 1'b1, 8'd0,   '{127, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[7] = '{M_CMP,   8'd100, 8, 1'b1, 1'b0, 8'd100, '{127, 63, 95, 111, 103, 99, 101, 100, 0}};
        vecs[8] = '{M_CMP,   8'd200, 8, 1'b1, 1'b0, 8'd200, '{127, 191, 223, 207, 199, 203, 201, 200, 0}};

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        fb_valid = 1'b0; fb_less = 1'b0; fb_equal = 1'b0; fb_great = 1'b0;
        fb_valid2 = 1'b0; fb_less2 = 1'b0; fb_equal2 = 1'b0; fb_great2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_outputs", {guess, guess_valid, busy, done, found, error, result, steps}, 0);
        check("rst_outputs_tmo", {guess2, guess_valid2, busy2, done2, found2, error2, result2, steps2}, 0);
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            run(vecs[k].mode, vecs[k].tgt, 1'b0);
            check_vec(k, 2 * vecs[k].ng + 1);
        end

        // Target 100 again with stray start and stray feedback outside ASK.
        run(M_CMP, 8'd100, 1'b1);
        check_vec(7, 17);

        // Reset while waiting in ASK after three answered guesses.
        gq.delete();
        seen  = 1'b0;
        start = 1'b1;
        for (int n = 0; n < 60 && gq.size() < 4; n++) begin
            @(negedge clk);
            start = 1'b0;
            fb_valid = 1'b0; fb_less = 1'b0; fb_equal = 1'b0; fb_great = 1'b0;
            if (guess_valid) begin
                gq.push_back(int'(guess));
                if (gq.size() <= 3) drive_fb(M_CMP, 8'd100, guess);
            end
        end
        check("pre_rst_guess4", (gq.size() == 4) ? gq[3] : -1, 111);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("no_timeout_when_disabled", {seen, guess_valid}, 1);
        check("steps_before_rst", steps, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_outputs", {guess, guess_valid, busy, done, found, error, result, steps}, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("no_done_after_rst", seen, 0);
        run(M_CMP, 8'd255, 1'b0);
        check_vec(0, 19);

        // Timeout instance: no feedback at all.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        m = 0;
        for (int n = 0; n < 10 && !guess_valid2; n++) @(negedge clk);
        check("tmo_guess_valid", guess_valid2, 1);
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (done2) begin
                seen = 1'b1;
                m    = n + 1;
            end
        end
        check("tmo_done_cycle", m, 6);
        check("tmo_error", error2, 1);
        check("tmo_found", found2, 0);
        check("tmo_steps", steps2, 0);
        check("tmo_result", result2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/binary_search_8bit.md
Name: binary_search_8bit

Overview:
- Sequential counterpart to the team's 8-bit magnitude comparator: finds an unknown target by binary search, issuing guesses and consuming less/equal/great verdicts.
- Verdicts come from a comparator instance or an external responder, with A = guess and B = target.
- Used by the final-project guessing game and by self-test logic that locates a hidden value in at most WIDTH+1 queries.

Parameters:
WIDTH, 8, bit width of guess, target range and result.
TIMEOUT, 0, cycles to wait for feedback in ASK before failing; 0 disables the timeout.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a search; sampled only in IDLE.
guess  output  WIDTH  current query value, presented as A to the comparator.
guess_valid  output  1  high while guess is presented and feedback is awaited.
fb_valid  input  1  feedback strobe; accepted only when guess_valid=1.
fb_less  input  1  guess < target.
fb_equal  input  1  guess == target.
fb_great  input  1  guess > target.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when a search ends.
found  output  1  target located; valid at done, held until next start.
error  output  1  search failed; valid at done, held until next start.
result  output  WIDTH  located value (0 on error); held until next start.
steps  output  4  number of feedbacks accepted in this search; held until next start.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE.
  - guess, result and steps are cleared to 0.
  - guess_valid, busy, done, found and error are cleared to 0.
  - Reset mid-search abandons the search immediately; no done pulse is produced.
- FSM states: IDLE, CALC, ASK, FINISH.
- IDLE:
  - start=1 sets lo=0, hi=2^WIDTH-1, steps=0, clears found, error and result, and moves to CALC.
  - busy=1 from the next cycle.
- CALC:
  - mid = (lo+hi)>>1, computed with a WIDTH+1 bit sum so it cannot overflow.
  - guess <= mid; moves to ASK.
- ASK:
  - guess_valid=1 and guess is held stable.
  - Stays in ASK until fb_valid=1.
- Feedback accepted in ASK (fb_valid=1):
  - steps increments.
  - Exactly fb_equal: result=guess, found=1, go to FINISH.
  - Exactly fb_less: if guess == 2^WIDTH-1, error=1 and go to FINISH; else lo=guess+1 and go to CALC.
  - Exactly fb_great: if guess == 0, error=1 and go to FINISH; else hi=guess-1 and go to CALC.
  - lo > hi after the update: error=1, go to FINISH.
  - Zero or more than one of the three verdict bits high: error=1, go to FINISH.
- Timeout: with TIMEOUT>0, TIMEOUT consecutive ASK cycles without fb_valid set error=1 and go to FINISH. steps is not incremented.
- FINISH:
  - done=1 for exactly one cycle; busy=0 and guess_valid=0 in that cycle.
  - Next state is IDLE.
- Latency:
  - start at edge t gives guess_valid=1 from t+2.
  - Feedback accepted at edge k gives the next guess valid from k+2.
  - The final feedback at edge k gives done at k+1.
- Guess sequence bound: at most WIDTH+1 guesses (9 for WIDTH=8), so steps never exceeds 9.
- Ignored inputs:
  - start is ignored outside IDLE, including in FINISH.
  - fb_valid is ignored outside ASK.
- guess_valid is low in IDLE, CALC and FINISH. guess retains its last value outside ASK.
- found and error are never both 1.

Test Plan:
- Target 255, responder driven by the comparator model -> guesses 127,191,223,239,247,251,253,254,255; done with found=1, result=255, steps=9.
- Target 0 -> guesses 127,63,31,15,7,3,1,0; found=1, result=0, steps=8. Target 127 -> single guess 127, steps=1, done exactly 3 cycles after start.
- Responder always answers less -> same guesses as target 255; fb_less at guess 255 gives error=1, found=0, result=0, steps=9.
- fb_valid with fb_less=fb_great=1 on the first guess -> error=1, steps=1. With TIMEOUT=5 and no feedback -> error=1 on the 6th cycle after guess_valid rises, steps=0.
- Target 100: assert start again mid-search (ignored, sequence unchanged) and a stray fb_valid during CALC (ignored) -> found=1, result=100.
- Assert rst while in ASK after 3 guesses -> next cycle all outputs are 0, no done pulse; a new start then runs a clean search from guess 127.
